// File: rtl/dram_prefetch_fifo.sv
// Prefetch FIFO between the DRAM read path and the accelerator DRAMdata input.
// Registered one-cycle pop latency, occupancy, almost-full and sticky error flags.
module dram_prefetch_fifo #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 32,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     DVAL,
  input  logic                     Rd_Req,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wrptr_q, wrptr_d;
  logic [AW-1:0]     rdptr_q, rdptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              oval_q, oval_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              pop, wr, mem_we;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AFULL_THRESH));

  assign pop    = Rd_Req && !empty;
  assign wr     = DVAL && (!full || pop);
  assign mem_we = wr && !flush;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    odata_d = odata_q;
    oval_d  = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr) wrptr_d = wrptr_q + AW'(1);
      if (pop) begin
        rdptr_d = rdptr_q + AW'(1);
        odata_d = mem_q[rdptr_q];
        oval_d  = 1'b1;
      end
      unique case ({wr, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // no bypass: a pop sees only words stored before this edge
      if (DVAL && full && !pop) ovf_d = 1'b1;
      if (Rd_Req && empty)      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      odata_q <= '0;
      oval_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      odata_q <= odata_d;
      oval_q  <= oval_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wrptr_q] <= in_data;
  end

  assign out_data  = odata_q;
  assign out_valid = oval_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
